// File: rtl/video_sink_monitor.sv
// video_sink_monitor: pixel-clock-side checker for the HS/VS/BLANK/RGB video stream.
// Per frame it measures active-run lengths, counts active lines and computes a
// 24-bit pixel checksum. It then compares the frame geometry against HDISP/VDISP
// and asserts 'locked' after LOCK_FRAMES consecutive conforming frames.
//
// Pipeline, relative to the pixel_clk edge t at which vs is first sampled low:
//   edge t   : inputs land in the *_r_q input registers
//   edge t+1 : edge detected on the registered copies; frame results captured (res_*_q)
//   edge t+2 : result outputs, frame_done and lock state updated together
//
// Streaming handshake: this block has no ready/valid. It accepts one pixel per
// cycle unconditionally, and frame_done acts as a one-cycle valid for the result
// outputs. Those outputs hold their value until the next frame is evaluated.
module video_sink_monitor #(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  input  logic [23:0] rgb,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_hdisp,
  output logic        err_vdisp,
  output logic [11:0] line_count,
  output logic [11:0] last_run,
  output logic [23:0] frame_sum,
  output logic        locked
);

  localparam logic [11:0] HDISP_L = HDISP[11:0];
  localparam logic [11:0] VDISP_L = VDISP[11:0];
  localparam logic [3:0]  LOCK_L  = LOCK_FRAMES[3:0];

  typedef enum logic {
    S_SYNC    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  // Saturating 12-bit increment used by the run and line counters.
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Input stage and previous-value copies used for edge detection.
  logic        vs_r_q, vs_r_d, vs_prev_q, vs_prev_d;
  logic        hs_r_q, hs_r_d;
  logic        blank_r_q, blank_r_d, blank_prev_q, blank_prev_d;
  logic [23:0] rgb_r_q, rgb_r_d;

  // Measurement state and accumulators.
  state_t      state_q, state_d;
  logic [11:0] run_q, run_d;
  logic [11:0] lines_q, lines_d;
  logic [11:0] last_acc_q, last_acc_d;
  logic        line_err_q, line_err_d;
  logic [23:0] sum_q, sum_d;

  // Captured frame results, waiting one cycle before publication.
  logic        pend_q, pend_d;
  logic [11:0] res_lines_q, res_lines_d;
  logic [11:0] res_last_q, res_last_d;
  logic [23:0] res_sum_q, res_sum_d;
  logic        res_herr_q, res_herr_d;
  logic        res_verr_q, res_verr_d;

  // Published results and lock tracking.
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic        err_h_q, err_h_d;
  logic        err_v_q, err_v_d;
  logic [11:0] line_count_q, line_count_d;
  logic [11:0] last_run_q, last_run_d;
  logic [23:0] frame_sum_q, frame_sum_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        locked_q, locked_d;

  // Edge detection and end-of-frame closing values.
  logic        vs_fall, in_run, run_end;
  logic [11:0] run_inc, close_len, fin_lines, fin_last;
  logic        fin_err;
  logic [23:0] fin_sum;

  // hs carries no information this measurement depends on; it is only registered.
  logic unused_hs;
  assign unused_hs = hs_r_q;

  // Input registers: capture the raw stream and keep one-cycle-old copies.
  always_comb begin
    vs_r_d       = vs;
    hs_r_d       = hs;
    blank_r_d    = blank;
    rgb_r_d      = rgb;
    vs_prev_d    = vs_r_q;
    blank_prev_d = blank_r_q;
  end

  // Edge detection, plus the values a frame would close with if this cycle were the VS edge.
  always_comb begin
    vs_fall   = vs_prev_q & ~vs_r_q;
    in_run    = blank_r_q & blank_prev_q;
    run_end   = blank_prev_q & ~blank_r_q;
    run_inc   = sat_inc(run_q);
    close_len = in_run ? run_inc : run_q;
    fin_lines = blank_prev_q ? sat_inc(lines_q) : lines_q;
    fin_err   = line_err_q | (blank_prev_q & (close_len != HDISP_L));
    fin_last  = blank_prev_q ? close_len : last_acc_q;
    fin_sum   = in_run ? (sum_q + rgb_r_q) : sum_q;
  end

  // Measurement FSM: hold accumulators in SYNC, accumulate and evaluate in MEASURE.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    lines_d     = lines_q;
    last_acc_d  = last_acc_q;
    line_err_d  = line_err_q;
    sum_d       = sum_q;
    pend_d      = 1'b0;
    res_lines_d = res_lines_q;
    res_last_d  = res_last_q;
    res_sum_d   = res_sum_q;
    res_herr_d  = res_herr_q;
    res_verr_d  = res_verr_q;
    case (state_q)
      S_SYNC: begin
        run_d      = 12'd0;
        lines_d    = 12'd0;
        last_acc_d = 12'd0;
        line_err_d = 1'b0;
        sum_d      = 24'd0;
        if (vs_fall) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (vs_fall) begin
          // Close the frame (including any open run) and start the next one empty;
          // the edge-cycle pixel belongs to the frame being closed or to none.
          pend_d      = 1'b1;
          res_lines_d = fin_lines;
          res_last_d  = fin_last;
          res_sum_d   = fin_sum;
          res_herr_d  = fin_err;
          res_verr_d  = (fin_lines != VDISP_L);
          run_d       = 12'd0;
          lines_d     = 12'd0;
          last_acc_d  = 12'd0;
          line_err_d  = 1'b0;
          sum_d       = 24'd0;
        end else begin
          run_d = blank_r_q ? run_inc : 12'd0;
          if (run_end) begin
            lines_d    = sat_inc(lines_q);
            last_acc_d = run_q;
            if (run_q != HDISP_L) begin
              line_err_d = 1'b1;
            end
          end
          if (blank_r_q) begin
            sum_d = sum_q + rgb_r_q;
          end
        end
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  // Publication stage: drive the outputs, pulse frame_done and update the lock counter.
  always_comb begin
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    err_h_d      = err_h_q;
    err_v_d      = err_v_q;
    line_count_d = line_count_q;
    last_run_d   = last_run_q;
    frame_sum_d  = frame_sum_q;
    good_cnt_d   = good_cnt_q;
    locked_d     = locked_q;
    if (pend_q) begin
      frame_done_d = 1'b1;
      frame_ok_d   = ~res_herr_q & ~res_verr_q;
      err_h_d      = res_herr_q;
      err_v_d      = res_verr_q;
      line_count_d = res_lines_q;
      last_run_d   = res_last_q;
      frame_sum_d  = res_sum_q;
      if (~res_herr_q & ~res_verr_q) begin
        good_cnt_d = (good_cnt_q >= LOCK_L) ? LOCK_L : good_cnt_q + 4'd1;
        locked_d   = (good_cnt_d == LOCK_L);
      end else begin
        good_cnt_d = 4'd0;
        locked_d   = 1'b0;
      end
    end
  end

  // All state registers; sync idles high, so vs copies reset to 1 to avoid a false edge.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      vs_r_q       <= 1'b1;
      vs_prev_q    <= 1'b1;
      hs_r_q       <= 1'b1;
      blank_r_q    <= 1'b0;
      blank_prev_q <= 1'b0;
      rgb_r_q      <= 24'd0;
      state_q      <= S_SYNC;
      run_q        <= 12'd0;
      lines_q      <= 12'd0;
      last_acc_q   <= 12'd0;
      line_err_q   <= 1'b0;
      sum_q        <= 24'd0;
      pend_q       <= 1'b0;
      res_lines_q  <= 12'd0;
      res_last_q   <= 12'd0;
      res_sum_q    <= 24'd0;
      res_herr_q   <= 1'b0;
      res_verr_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_h_q      <= 1'b0;
      err_v_q      <= 1'b0;
      line_count_q <= 12'd0;
      last_run_q   <= 12'd0;
      frame_sum_q  <= 24'd0;
      good_cnt_q   <= 4'd0;
      locked_q     <= 1'b0;
    end else begin
      vs_r_q       <= vs_r_d;
      vs_prev_q    <= vs_prev_d;
      hs_r_q       <= hs_r_d;
      blank_r_q    <= blank_r_d;
      blank_prev_q <= blank_prev_d;
      rgb_r_q      <= rgb_r_d;
      state_q      <= state_d;
      run_q        <= run_d;
      lines_q      <= lines_d;
      last_acc_q   <= last_acc_d;
      line_err_q   <= line_err_d;
      sum_q        <= sum_d;
      pend_q       <= pend_d;
      res_lines_q  <= res_lines_d;
      res_last_q   <= res_last_d;
      res_sum_q    <= res_sum_d;
      res_herr_q   <= res_herr_d;
      res_verr_q   <= res_verr_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_h_q      <= err_h_d;
      err_v_q      <= err_v_d;
      line_count_q <= line_count_d;
      last_run_q   <= last_run_d;
      frame_sum_q  <= frame_sum_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign err_hdisp  = err_h_q;
  assign err_vdisp  = err_v_q;
  assign line_count = line_count_q;
  assign last_run   = last_run_q;
  assign frame_sum  = frame_sum_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_video_sink_monitor.sv
// Bench for video_sink_monitor.
// Instance a: 160x90 geometry, nominal frames and the checksum wrap.
// Instance b: 8x4 geometry, error, lock, mid-run VS edge and mid-frame reset cases.
module tb_video_sink_monitor;

  localparam int W = 52;  // {ok, err_h, err_v, locked, line_count, last_run, frame_sum}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        hs_a, vs_a, blank_a, hs_b, vs_b, blank_b;
  logic [23:0] rgb_a, rgb_b;
  logic        done_a, ok_a, eh_a, ev_a, lk_a;
  logic        done_b, ok_b, eh_b, ev_b, lk_b;
  logic [11:0] lc_a, lr_a, lc_b, lr_b;
  logic [23:0] sum_a, sum_b;

  video_sink_monitor #(.HDISP(160), .VDISP(90), .LOCK_FRAMES(2)) dut_a (
    .pixel_clk(clk), .pixel_rst(rst_a), .hs(hs_a), .vs(vs_a), .blank(blank_a), .rgb(rgb_a),
    .frame_done(done_a), .frame_ok(ok_a), .err_hdisp(eh_a), .err_vdisp(ev_a),
    .line_count(lc_a), .last_run(lr_a), .frame_sum(sum_a), .locked(lk_a)
  );

  video_sink_monitor #(.HDISP(8), .VDISP(4), .LOCK_FRAMES(2)) dut_b (
    .pixel_clk(clk), .pixel_rst(rst_b), .hs(hs_b), .vs(vs_b), .blank(blank_b), .rgb(rgb_b),
    .frame_done(done_b), .frame_ok(ok_b), .err_hdisp(eh_b), .err_vdisp(ev_b),
    .line_count(lc_b), .last_run(lr_b), .frame_sum(sum_b), .locked(lk_b)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] pack(input logic ok, input logic eh, input logic ev,
                                         input logic lk, input logic [11:0] lines,
                                         input logic [11:0] last, input logic [23:0] sum);
    return {ok, eh, ev, lk, lines, last, sum};
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    cmp({tag, ".frame_ok"},   32'(got[51]),    32'(want[51]));
    cmp({tag, ".err_hdisp"},  32'(got[50]),    32'(want[50]));
    cmp({tag, ".err_vdisp"},  32'(got[49]),    32'(want[49]));
    cmp({tag, ".locked"},     32'(got[48]),    32'(want[48]));
    cmp({tag, ".line_count"}, 32'(got[47:36]), 32'(want[47:36]));
    cmp({tag, ".last_run"},   32'(got[35:24]), 32'(want[35:24]));
    cmp({tag, ".frame_sum"},  32'(got[23:0]),  32'(want[23:0]));
  endtask

  // Monitor: every frame_done pops one expected result per instance.
  always @(negedge clk) begin
    if (done_a) begin
      if (exp_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a.unexpected_frame_done: got pulse, expected none");
      end else begin
        check_frame("a", {ok_a, eh_a, ev_a, lk_a, lc_a, lr_a, sum_a}, exp_a.pop_front());
      end
    end
    if (done_b) begin
      if (exp_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b.unexpected_frame_done: got pulse, expected none");
      end else begin
        check_frame("b", {ok_b, eh_b, ev_b, lk_b, lc_b, lr_b, sum_b}, exp_b.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One pixel-clock cycle of stimulus; hs toggles randomly since it must not matter.
  task automatic drive(input bit sel, input logic v, input logic bl, input logic [23:0] px);
    @(negedge clk);
    if (sel) begin
      vs_b = v; blank_b = bl; rgb_b = px; hs_b = 1'($urandom_range(0, 1));
    end else begin
      vs_a = v; blank_a = bl; rgb_a = px; hs_a = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic line(input bit sel, input int len, input logic [23:0] px);
    for (int i = 0; i < len; i++) drive(sel, 1'b1, 1'b1, px);
    drive(sel, 1'b1, 1'b0, 24'd0);
    drive(sel, 1'b1, 1'b0, 24'd0);
  endtask

  task automatic frame(input bit sel, input int n, input int len, input logic [23:0] px);
    for (int i = 0; i < n; i++) line(sel, len, px);
  endtask

  task automatic vs_edge(input bit sel);
    drive(sel, 1'b0, 1'b0, 24'd0);
    drive(sel, 1'b0, 1'b0, 24'd0);
    drive(sel, 1'b1, 1'b0, 24'd0);
    drive(sel, 1'b1, 1'b0, 24'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    vs_a = 1'b1; blank_a = 1'b0; rgb_a = 24'd0; hs_a = 1'b1;
    vs_b = 1'b1; blank_b = 1'b0; rgb_b = 24'd0; hs_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    check_frame("a.reset", {ok_a, eh_a, ev_a, lk_a, lc_a, lr_a, sum_a}, '0);
    cmp("a.reset.frame_done", 32'(done_a), 32'd0);
    check_frame("b.reset", {ok_b, eh_b, ev_b, lk_b, lc_b, lr_b, sum_b}, '0);
    cmp("b.reset.frame_done", 32'(done_b), 32'd0);

    // Instance a: sync edge, two nominal frames, then the checksum wrap frame.
    vs_edge(0);
    frame(0, 90, 160, 24'h000001);
    exp_a.push_back(pack(1, 0, 0, 0, 12'd90, 12'd160, 24'h003840));
    vs_edge(0);
    frame(0, 90, 160, 24'h000001);
    exp_a.push_back(pack(1, 0, 0, 1, 12'd90, 12'd160, 24'h003840));
    vs_edge(0);
    frame(0, 90, 160, 24'hFFFFFF);
    exp_a.push_back(pack(1, 0, 0, 1, 12'd90, 12'd160, 24'hFFC7C0));
    vs_edge(0);

    // Instance b: lock, short line, relock, line count errors.
    vs_edge(1);
    frame(1, 4, 8, 24'd1);
    exp_b.push_back(pack(1, 0, 0, 0, 12'd4, 12'd8, 24'd32));
    vs_edge(1);
    frame(1, 4, 8, 24'd2);
    exp_b.push_back(pack(1, 0, 0, 1, 12'd4, 12'd8, 24'd64));
    vs_edge(1);
    line(1, 8, 24'd1); line(1, 7, 24'd1); line(1, 8, 24'd1); line(1, 8, 24'd1);
    exp_b.push_back(pack(0, 1, 0, 0, 12'd4, 12'd8, 24'd31));
    vs_edge(1);
    frame(1, 4, 8, 24'd1);
    exp_b.push_back(pack(1, 0, 0, 0, 12'd4, 12'd8, 24'd32));
    vs_edge(1);
    frame(1, 4, 8, 24'd1);
    exp_b.push_back(pack(1, 0, 0, 1, 12'd4, 12'd8, 24'd32));
    vs_edge(1);
    frame(1, 3, 8, 24'd1);
    exp_b.push_back(pack(0, 0, 1, 0, 12'd3, 12'd8, 24'd24));
    vs_edge(1);
    frame(1, 5, 8, 24'd1);
    exp_b.push_back(pack(0, 0, 1, 0, 12'd5, 12'd8, 24'd40));
    vs_edge(1);

    // VS falls on the 5th pixel of the third line; three more pixels follow the edge.
    frame(1, 2, 8, 24'd1);
    exp_b.push_back(pack(0, 1, 1, 0, 12'd3, 12'd5, 24'd21));
    for (int i = 0; i < 4; i++) drive(1, 1'b1, 1'b1, 24'd1);
    drive(1, 1'b0, 1'b1, 24'd1);
    drive(1, 1'b0, 1'b1, 24'd1);
    drive(1, 1'b1, 1'b1, 24'd1);
    drive(1, 1'b1, 1'b1, 24'd1);
    drive(1, 1'b1, 1'b0, 24'd0);
    drive(1, 1'b1, 1'b0, 24'd0);
    frame(1, 3, 8, 24'd1);
    exp_b.push_back(pack(0, 1, 0, 0, 12'd4, 12'd8, 24'd27));
    vs_edge(1);

    // One-cycle reset in the middle of a line.
    frame(1, 2, 8, 24'd1);
    drive(1, 1'b1, 1'b1, 24'd1);
    rst_b = 1'b1;
    drive(1, 1'b1, 1'b1, 24'd1);
    rst_b = 1'b0;
    check_frame("b.mid_reset", {ok_b, eh_b, ev_b, lk_b, lc_b, lr_b, sum_b}, '0);
    cmp("b.mid_reset.frame_done", 32'(done_b), 32'd0);
    drive(1, 1'b1, 1'b1, 24'd1);
    drive(1, 1'b1, 1'b0, 24'd0);
    drive(1, 1'b1, 1'b0, 24'd0);
    line(1, 8, 24'd1);
    vs_edge(1);
    frame(1, 4, 8, 24'd1);
    exp_b.push_back(pack(1, 0, 0, 0, 12'd4, 12'd8, 24'd32));
    vs_edge(1);

    repeat (10) drive(1, 1'b1, 1'b0, 24'd0);
    cmp("a.results_outstanding", 32'(exp_a.size()), 32'd0);
    cmp("b.results_outstanding", 32'(exp_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
